// File: rtl/decoder_n_seq.sv
// Sequenced N-to-2^N decoder: handshaked one-hot / thermometer decode plus a
// prescaled auto-scan walking a single bit across the output.
module decoder_n_seq #(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 2**IN_W,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [IN_W-1:0]   in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic [IN_W-1:0]   scan_idx
);

  localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {OFF, DEC, SCAN} state_t;

  state_t              state;
  state_t              nxt;
  logic [PW-1:0]       presc;
  logic [IN_W-1:0]     idx_inc;
  logic [OUT_W-1:0]    onehot;
  logic [OUT_W-1:0]    therm;
  logic [OUT_W-1:0]    step_pat;

  // Target state depends only on the current enable/mode, so it is rechecked every cycle.
  always_comb begin
    if (!en || mode == 2'b11) nxt = OFF;
    else if (mode == 2'b10)   nxt = SCAN;
    else                      nxt = DEC;
  end

  assign in_ready = en & ~mode[1];
  assign idx_inc  = scan_idx + 1'b1;   // OUT_W is a power of two, so this wraps naturally

  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pat
      assign onehot[gi]   = (in == IN_W'(gi));
      assign therm[gi]    = (IN_W'(gi) <= in);
      assign step_pat[gi] = (idx_inc == IN_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      out       <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      presc     <= '0;
    end else begin
      state     <= nxt;
      out_valid <= 1'b0;
      if (nxt == OFF) begin
        out      <= '0;
        scan_idx <= '0;
        presc    <= '0;
      end else if (nxt == SCAN) begin
        if (state != SCAN) begin
          scan_idx  <= '0;
          out       <= OUT_W'(1);
          out_valid <= 1'b1;
          presc     <= '0;
        end else if (presc == PS_LAST) begin
          presc     <= '0;
          scan_idx  <= idx_inc;
          out       <= step_pat;
          out_valid <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        // Decode: out keeps its last value (including a scan value) until an accept.
        scan_idx <= '0;
        presc    <= '0;
        if (in_valid) begin
          out       <= mode[0] ? therm : onehot;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq (IN_W=3, SCAN_DIV=4): directed vector
// table, hand-written scan/reset/mode-switch sequences and randomized traffic.
module tb_decoder_n_seq;

  localparam int IW = 3;
  localparam int OW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b11;
  logic [IW-1:0] in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out;
  logic          out_valid;
  logic [IW-1:0] scan_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state: scan position derived from cycles since scan entry.
  logic [7:0] m_out;
  logic       m_valid;
  int         m_idx;
  bit         in_scan;
  int         k;

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic       v;
    logic [2:0] i;
    logic [7:0] x_out;
    logic       x_valid;
    logic [2:0] x_idx;
    logic       x_ready;
  } vec_t;

  vec_t vecs [15];

  decoder_n_seq #(.IN_W(IW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_valid = 1'b0; m_idx = 0; in_scan = 0; k = 0;
  endtask

  task automatic model_edge();
    if (!en || mode == 2'b11) begin
      m_out = '0; m_valid = 1'b0; m_idx = 0; in_scan = 0;
    end else if (mode == 2'b10) begin
      if (!in_scan) begin in_scan = 1; k = 0; end
      else k++;
      m_idx   = (k / SD) % OW;
      m_valid = ((k % SD) == 0);
      if (m_valid) m_out = 8'(1 << m_idx);
    end else begin
      in_scan = 0;
      m_idx   = 0;
      m_valid = in_valid;
      if (in_valid) m_out = (mode == 2'b00) ? 8'(1 << int'(in)) : 8'((2 << int'(in)) - 1);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".scan_idx"}, 32'(scan_idx), 32'(m_idx));
  endtask

  // Drive one cycle of inputs, check in_ready, clock, advance the model.
  task automatic apply(input logic e, input logic [1:0] m, input logic v, input logic [2:0] i);
    en = e; mode = m; in_valid = v; in = i;
    #1;
    chk("in_ready", 32'(in_ready), 32'(e && !m[1]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic setv(input int n, input logic e, input logic [1:0] m, input logic v,
                      input logic [2:0] i, input logic [7:0] xo, input logic xv,
                      input logic [2:0] xi, input logic xr);
    vecs[n].e = e; vecs[n].m = m; vecs[n].v = v; vecs[n].i = i;
    vecs[n].x_out = xo; vecs[n].x_valid = xv; vecs[n].x_idx = xi; vecs[n].x_ready = xr;
  endtask

  initial begin
    int pulses;
    setv(0,  1, 2'b00, 1, 3'd0, 8'h01, 1, 0, 1);
    setv(1,  1, 2'b00, 1, 3'd1, 8'h02, 1, 0, 1);
    setv(2,  1, 2'b00, 1, 3'd2, 8'h04, 1, 0, 1);
    setv(3,  1, 2'b00, 1, 3'd3, 8'h08, 1, 0, 1);
    setv(4,  1, 2'b00, 1, 3'd4, 8'h10, 1, 0, 1);
    setv(5,  1, 2'b00, 1, 3'd5, 8'h20, 1, 0, 1);
    setv(6,  1, 2'b00, 1, 3'd6, 8'h40, 1, 0, 1);
    setv(7,  1, 2'b00, 1, 3'd7, 8'h80, 1, 0, 1);
    setv(8,  1, 2'b01, 1, 3'd5, 8'h3F, 1, 0, 1);
    setv(9,  1, 2'b01, 0, 3'd2, 8'h3F, 0, 0, 1);
    setv(10, 0, 2'b00, 1, 3'd3, 8'h00, 0, 0, 0);
    setv(11, 1, 2'b00, 1, 3'd3, 8'h08, 1, 0, 1);
    setv(12, 1, 2'b11, 1, 3'd3, 8'h00, 0, 0, 0);
    setv(13, 1, 2'b01, 1, 3'd0, 8'h01, 1, 0, 1);
    setv(14, 1, 2'b01, 1, 3'd7, 8'hFF, 1, 0, 1);

    model_reset();
    #12;
    chk("reset.out", 32'(out), 32'h0);
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.scan_idx", 32'(scan_idx), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int n = 0; n < 15; n++) begin
      en = vecs[n].e; mode = vecs[n].m; in_valid = vecs[n].v; in = vecs[n].i;
      #1;
      chk("vec.in_ready", 32'(in_ready), 32'(vecs[n].x_ready));
      @(posedge clk);
      model_edge();
      #1;
      chk("vec.out", 32'(out), 32'(vecs[n].x_out));
      chk("vec.out_valid", 32'(out_valid), 32'(vecs[n].x_valid));
      chk("vec.scan_idx", 32'(scan_idx), 32'(vecs[n].x_idx));
      $display("vec %0d en=%0b mode=%0d v=%0b in=%0d -> out=%02h valid=%0b",
               n, vecs[n].e, vecs[n].m, vecs[n].v, vecs[n].i, out, out_valid);
    end

    // Scan wrap: 36 cycles of MODE=10 from OFF
    apply(0, 2'b00, 0, 0);
    pulses = 0;
    for (int c = 1; c <= 36; c++) begin
      apply(1, 2'b10, 1, 3'(c));
      cmp_model("scan");
      if (out_valid) pulses++;
      if (c == 1)  chk("scan.first", 32'(out), 32'h01);
      if (c == 29) chk("scan.idx7", 32'(scan_idx), 32'd7);
      if (c == 29) chk("scan.top", 32'(out), 32'h80);
      if (c == 32) chk("scan.hold", 32'(out), 32'h80);
      if (c == 33) chk("scan.wrap_out", 32'(out), 32'h01);
      if (c == 33) chk("scan.wrap_idx", 32'(scan_idx), 32'd0);
    end
    chk("scan.pulses", 32'(pulses), 32'd9);
    $display("scan wrap: %0d pulses, final out=%02h idx=%0d", pulses, out, scan_idx);

    // Mode switch: scan to 08 then decode
    apply(0, 2'b00, 0, 0);
    for (int c = 1; c <= 13; c++) apply(1, 2'b10, 0, 0);
    chk("switch.scan_out", 32'(out), 32'h08);
    chk("switch.scan_idx", 32'(scan_idx), 32'd3);
    apply(1, 2'b00, 0, 3'd2);
    chk("switch.hold_out", 32'(out), 32'h08);
    chk("switch.idx_clear", 32'(scan_idx), 32'd0);
    chk("switch.no_pulse", 32'(out_valid), 32'd0);
    apply(1, 2'b00, 1, 3'd6);
    chk("switch.accept", 32'(out), 32'h40);
    chk("switch.accept_valid", 32'(out_valid), 32'd1);
    $display("mode switch: out=%02h", out);

    // Asynchronous reset mid-scan
    for (int c = 1; c <= 6; c++) apply(1, 2'b10, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.out", 32'(out), 32'h0);
    chk("areset.scan_idx", 32'(scan_idx), 32'h0);
    chk("areset.out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("areset.held", 32'(out), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("areset.rel_out", 32'(out), 32'h01);
    chk("areset.rel_valid", 32'(out_valid), 32'd1);
    in_scan = 1; k = 0; m_out = 8'h01; m_valid = 1'b1; m_idx = 0;
    $display("async reset: resumed out=%02h", out);

    // Randomized traffic vs reference model
    begin
      int remain;
      logic       r_en;
      logic [1:0] r_mode;
      remain = 0; r_en = 1'b1; r_mode = 2'b10;
      for (int c = 0; c < 400; c++) begin
        if (remain == 0) begin
          remain = $urandom_range(1, 40);
          r_mode = 2'($urandom_range(0, 3));
        end
        remain--;
        r_en = ($urandom_range(0, 15) != 0);
        apply(r_en, r_mode, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        cmp_model("rand");
      end
      $display("random: 400 cycles done");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 Parameter IN_W, default 3, select width; SHALL be at least 1.
REQ-002 Parameter OUT_W, default 2**IN_W, output width; derived, SHALL NOT be overridden.
REQ-003 Parameter SCAN_DIV, default 4, clock cycles per scan step; SHALL be at least 1.
REQ-004 CLK  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  block enable; low SHALL force disabled behaviour.
REQ-007 MODE  input  2  00 one-hot decode, 01 thermometer, 10 auto-scan, 11 off.
REQ-008 IN  input  IN_W  select code, sampled only on an accepted handshake.
REQ-009 IN_VALID  input  1  IN holds a code to be decoded.
REQ-010 IN_READY  output  1  block accepts IN this cycle.
REQ-011 OUT  output  OUT_W  registered decoded pattern.
REQ-012 OUT_VALID  output  1  single-cycle pulse marking a new OUT value.
REQ-013 SCAN_IDX  output  IN_W  registered current scan position.

Function
REQ-014 IN_READY SHALL be combinational: EN=1 and MODE is 00 or 01.
REQ-015 An accept (IN_VALID=1 and IN_READY=1) in MODE 00 SHALL register OUT = 1 << IN on that edge. The new value is visible the next cycle (latency 1).
REQ-016 An accept in MODE 01 SHALL register OUT with bits [IN:0] set and all other bits clear. Example: IN=0 gives OUT=...0001.
REQ-017 Each accept SHALL pulse OUT_VALID high for exactly the one cycle after the accepting edge. Back-to-back accepts SHALL give a pulse every cycle.
REQ-018 In MODE 00/01 with no accept, OUT SHALL hold its last value and OUT_VALID SHALL be 0.
REQ-019 The FSM SHALL have the states OFF, DEC and SCAN.
  - OFF when EN=0 or MODE=11.
  - DEC when EN=1 and MODE is 00 or 01.
  - SCAN when EN=1 and MODE=10.
  - State SHALL be re-evaluated every cycle from EN/MODE.
REQ-020 Entering OFF SHALL, on the next edge, clear OUT to 0 and SCAN_IDX to 0, clear the prescaler, and hold OUT_VALID at 0.
REQ-021 Entering SCAN from any other state SHALL, on the first edge, set SCAN_IDX=0 and OUT=1 (bit 0), pulse OUT_VALID, and clear the prescaler.
REQ-022 In SCAN, the prescaler SHALL count 0..SCAN_DIV-1.
  - On each terminal count, SCAN_IDX increments and OUT = 1 << (new SCAN_IDX), with an OUT_VALID pulse.
  - Steps SHALL therefore occur every SCAN_DIV cycles.
REQ-023 SCAN_IDX SHALL wrap from OUT_W-1 to 0 with no extra cycle.
REQ-024 With SCAN_DIV=1, SCAN SHALL advance one position every cycle, with OUT_VALID continuously high.
REQ-025 Leaving SCAN for DEC SHALL hold OUT at its last scan value and clear SCAN_IDX and the prescaler. The first accept SHALL then behave per REQ-015/016.
REQ-026 EN=0 SHALL take priority over IN_VALID and MODE in the same cycle. No accept SHALL occur.
REQ-027 IN SHALL be ignored when not accepted. All IN codes 0..OUT_W-1 SHALL be legal; no default/illegal case SHALL exist.

Reset
REQ-028 RST_N low SHALL, asynchronously, set OUT=0, OUT_VALID=0, SCAN_IDX=0, prescaler=0 and state=OFF.
REQ-029 Release SHALL be synchronised to CLK. Operation SHALL resume on the first edge after RST_N goes high.
REQ-030 Reset asserted mid-scan or mid-handshake SHALL discard the pending step or accept.

Verification (IN_W=3, SCAN_DIV=4)
REQ-031 Decode sweep: EN=1, MODE=00, IN_VALID=1 with IN=0..7 on consecutive cycles -> OUT = 01,02,04,...,80 one cycle later each, with OUT_VALID high for 8 cycles.
REQ-032 Thermometer: MODE=01, accept IN=5 -> OUT=8'h3F, OUT_VALID one pulse; then IN_VALID=0 -> OUT holds 3F, OUT_VALID=0.
REQ-033 Scan wrap: MODE=10 for 36 cycles -> OUT=01 at the first edge, then advancing every 4 cycles through 80 and back to 01. SCAN_IDX goes 7->0, with 9 OUT_VALID pulses.
REQ-034 Priority/off: EN=0 with IN_VALID=1 and IN=3 -> IN_READY=0, OUT=00 next cycle, no pulse. MODE=11 with EN=1 -> same result.
REQ-035 Async reset: assert RST_N low mid-scan between clock edges -> OUT=00 and SCAN_IDX=0 immediately. After release with MODE=10 -> OUT=01 on the first edge.
REQ-036 Mode switch: scan at OUT=8'h08, then switch to MODE=00 -> OUT holds 08. Then accept IN=6 -> OUT=8'h40.
